// File: rtl/i2s_tx_ctrl.sv
// rtl/i2s_tx_ctrl.sv - I2S transmit framing controller (ws/sd generation, FIFO bit pacing)
// Optional underrun counter: define I2S_TX_UNDERRUN_CNT_EN to add the underrun_cnt port.
module i2s_tx_ctrl #(
  parameter int   UCNT_W  = 8,
  parameter logic IDLE_WS = 1'b0
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              frame_size,
  input  logic              mute,
  input  logic              stop,
  input  logic              fifo_empty,
  input  logic              fifo_dout,
  output logic              rd_en,
  output logic              ws,
  output logic              sd,
  output logic              busy,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output logic              underrun,
  output logic [UCNT_W-1:0] underrun_cnt
`else
  output logic              underrun
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] cnt;
  logic       n32;
  logic       skip;
  logic [4:0] last_idx;
  logic       word_end;

  // Index of the LSB for the word length latched at the start of this frame
  assign last_idx = n32 ? 5'd31 : 5'd15;
  assign word_end = (cnt == last_idx);

  // FIFO is advanced on every active bit unless the current word is a zero-filled underrun word
  assign busy  = (state != IDLE);
  assign rd_en = busy & ~skip;

  // Framing FSM: state, bit counter, word length, skip flag, ws/sd and underrun pulse
  always_ff @(posedge sclk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      n32      <= 1'b0;
      skip     <= 1'b0;
      ws       <= IDLE_WS;
      sd       <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          sd <= 1'b0;
          if (!stop && !fifo_empty) begin
            state <= LEFT;
            cnt   <= 5'd0;
            skip  <= 1'b0;
            n32   <= frame_size;
            // Left channel is selected one sclk ahead of its MSB
            ws    <= 1'b0;
          end else begin
            ws <= IDLE_WS;
          end
        end
        LEFT, RIGHT: begin
          sd <= (mute | skip) ? 1'b0 : fifo_dout;
          if (word_end) begin
            cnt <= 5'd0;
            if (state == RIGHT && stop) begin
              state <= IDLE;
              skip  <= 1'b0;
              ws    <= IDLE_WS;
            end else begin
              // ws flips together with the LSB, leading the next word's MSB by one sclk
              state    <= (state == LEFT) ? RIGHT : LEFT;
              ws       <= (state == LEFT);
              skip     <= fifo_empty;
              underrun <= fifo_empty;
              if (state == RIGHT) begin
                n32 <= frame_size;
              end
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 5'd0;
          skip  <= 1'b0;
          ws    <= IDLE_WS;
          sd    <= 1'b0;
        end
      endcase
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  // Saturating count of underrun pulses, cleared only by reset
  always_ff @(posedge sclk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (underrun && (underrun_cnt != {UCNT_W{1'b1}})) begin
      underrun_cnt <= underrun_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// tb/tb_i2s_tx_ctrl.sv - directed self-checking bench for i2s_tx_ctrl
module tb_i2s_tx_ctrl;

  logic sclk = 1'b0;
  logic rst = 1'b1;
  logic frame_size = 1'b0;
  logic mute = 1'b0;
  logic stop = 1'b1;
  logic fifo_empty = 1'b1;
  logic fifo_dout = 1'b0;
  logic rd_en, ws, sd, busy, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int pops = 0;
  logic q[$];

  logic [31:0] sdv, wsv;
  int rdc, udc;

  i2s_tx_ctrl #(.UCNT_W(8), .IDLE_WS(1'b0)) dut (
    .sclk(sclk),
    .rst(rst),
    .frame_size(frame_size),
    .mute(mute),
    .stop(stop),
    .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout),
    .rd_en(rd_en),
    .ws(ws),
    .sd(sd),
    .busy(busy),
`ifdef I2S_TX_UNDERRUN_CNT_EN
    .underrun(underrun),
    .underrun_cnt(underrun_cnt)
`else
    .underrun(underrun)
`endif
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit FIFO model: empty once the bit being consumed this cycle is its last
  task automatic upd();
    fifo_dout  = (q.size() > 0) ? q[0] : 1'b0;
    fifo_empty = (q.size() <= (rd_en ? 1 : 0));
  endtask

  task automatic step();
    logic p;
    p = rd_en;
    @(posedge sclk);
    #1;
    if (p) begin
      pops++;
      if (q.size() > 0) void'(q.pop_front());
    end
    upd();
  endtask

  task automatic push(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) q.push_back(w[i]);
    upd();
  endtask

  task automatic collect(input int n, output logic [31:0] s, output logic [31:0] w,
                         output int rc, output int uc);
    s = '0;
    w = '0;
    uc = 0;
    pops = 0;
    for (int i = 0; i < n; i++) begin
      step();
      s = {s[30:0], sd};
      w = {w[30:0], ws};
      if (underrun) uc++;
    end
    rc = pops;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ws", 32'(ws), 32'd0);
    chk("rst_sd", 32'(sd), 32'd0);
    chk("rst_rden", 32'(rd_en), 32'd0);
    chk("rst_under", 32'(underrun), 32'd0);
    rst = 1'b0;

    // 16-bit frame, stop requested during LEFT
    push(32'h0000A5C3, 16);
    push(32'h00000F0F, 16);
    stop = 1'b0;
    step();
    chk("f16_busy", 32'(busy), 32'd1);
    chk("f16_ws0", 32'(ws), 32'd0);
    chk("f16_sd0", 32'(sd), 32'd0);
    stop = 1'b1;
    collect(32, sdv, wsv, rdc, udc);
    chk("f16_sd", sdv, 32'hA5C30F0F);
    chk("f16_ws", wsv, 32'h0001FFFE);
    chk("f16_rden", rdc, 32'd32);
    chk("f16_under", udc, 32'd0);
    chk("f16_idle", 32'(busy), 32'd0);
    step();
    chk("f16_sd_idle", 32'(sd), 32'd0);

    // Reset mid-LEFT at cnt=7
    push(32'h0000FFFF, 16);
    push(32'h0000FFFF, 16);
    stop = 1'b0;
    step();
    repeat (7) step();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ws", 32'(ws), 32'd0);
    chk("mid_rst_sd", 32'(sd), 32'd0);
    chk("mid_rst_rden", 32'(rd_en), 32'd0);
    step();
    rst = 1'b0;
    stop = 1'b1;
    q.delete();
    upd();
    step();
    chk("mid_rst_hold", 32'(busy), 32'd0);

    // 32-bit frame
    frame_size = 1'b1;
    push(32'h80000001, 32);
    push(32'h00000000, 32);
    stop = 1'b0;
    step();
    stop = 1'b1;
    frame_size = 1'b0;
    collect(32, sdv, wsv, rdc, udc);
    chk("f32_sd", sdv, 32'h80000001);
    chk("f32_ws_left", wsv, 32'h00000001);
    chk("f32_rden", rdc, 32'd32);
    collect(32, sdv, wsv, rdc, udc);
    chk("f32_ws_right", wsv, 32'hFFFFFFFE);
    chk("f32_idle", 32'(busy), 32'd0);

    // Underrun at RIGHT start
    push(32'h0000FFFF, 16);
    stop = 1'b0;
    step();
    stop = 1'b1;
    collect(16, sdv, wsv, rdc, udc);
    chk("ur_left_sd", sdv, 32'h0000FFFF);
    chk("ur_left_rden", rdc, 32'd16);
    chk("ur_pulse", 32'(underrun), 32'd1);
    chk("ur_pulse_cnt", udc, 32'd1);
    collect(16, sdv, wsv, rdc, udc);
    chk("ur_right_sd", sdv, 32'h00000000);
    chk("ur_right_rden", rdc, 32'd0);
    chk("ur_right_ws", wsv, 32'h0000FFFE);
    chk("ur_single", udc, 32'd0);
    chk("ur_idle", 32'(busy), 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("ur_count", 32'(underrun_cnt), 32'd1);
`endif

    // Mute with data queued
    push(32'h0000FFFF, 16);
    push(32'h0000FFFF, 16);
    mute = 1'b1;
    stop = 1'b0;
    step();
    stop = 1'b1;
    collect(32, sdv, wsv, rdc, udc);
    chk("mute_sd", sdv, 32'h00000000);
    chk("mute_rden", rdc, 32'd32);
    chk("mute_under", udc, 32'd0);
    mute = 1'b0;
    chk("mute_idle", 32'(busy), 32'd0);

    // Stop at LEFT cnt=3 with frame_size toggled mid-word
    push(32'h0000AAAA, 16);
    push(32'h00005555, 16);
    frame_size = 1'b0;
    stop = 1'b0;
    step();
    repeat (3) step();
    stop = 1'b1;
    frame_size = 1'b1;
    collect(28, sdv, wsv, rdc, udc);
    chk("stop_busy_e32", 32'(busy), 32'd1);
    step();
    chk("stop_idle_e33", 32'(busy), 32'd0);
    frame_size = 1'b0;

    // frame_size change takes effect at the next frame
    push(32'h00001234, 16);
    push(32'h00005678, 16);
    push(32'hDEADBEEF, 32);
    push(32'hCAFEF00D, 32);
    stop = 1'b0;
    step();
    repeat (4) step();
    frame_size = 1'b1;
    collect(28, sdv, wsv, rdc, udc);
    chk("rl_ws_edge", wsv & 32'h3, 32'h2);
    chk("rl_busy", 32'(busy), 32'd1);
    collect(32, sdv, wsv, rdc, udc);
    chk("rl_sd_left", sdv, 32'hDEADBEEF);
    chk("rl_ws_left", wsv, 32'h00000001);
    stop = 1'b1;
    collect(32, sdv, wsv, rdc, udc);
    chk("rl_sd_right", sdv, 32'hCAFEF00D);
    chk("rl_ws_right", wsv, 32'hFFFFFFFE);
    chk("rl_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
